// File: rtl/not_not_judge.sv
// Not-Not player-response judge: times one round per round_start, grades the
// synchronised switch answer against the generator mask, and tracks score/lives.
`timescale 1ns/1ps
module not_not_judge #(
  parameter int unsigned CYCLES_PER_ROUND = 100_000_000,
  parameter int unsigned START_LIVES      = 3,
  parameter int unsigned MAX_SCORE        = 99
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       round_start,
  input  logic [3:0] expected,
  input  logic [3:0] player_sw,
  input  logic       submit_n,
  output logic       armed,
  output logic       round_done,
  output logic       correct,
  output logic       timeout,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int unsigned   CW         = $clog2(CYCLES_PER_ROUND);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(CYCLES_PER_ROUND - 1);
  localparam logic [7:0]    SCORE_MAX  = 8'(MAX_SCORE);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RESULT,
    S_OVER
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    exp_q, exp_d;
  logic          correct_q, correct_d;
  logic          timeout_q, timeout_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;

  logic [3:0]    sw_s1_q, sw_s2_q;
  logic          sub_s1_q, sub_s2_q, sub_s3_q;

  logic          press;
  logic          sw_one_hot;
  logic          answer_ok;

  // submit_n idles high, so its synchroniser resets to 1 to avoid a phantom press
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      correct_q <= 1'b0;
      timeout_q <= 1'b0;
      score_q   <= '0;
      lives_q   <= LIVES_INIT;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      sub_s1_q  <= 1'b1;
      sub_s2_q  <= 1'b1;
      sub_s3_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      correct_q <= correct_d;
      timeout_q <= timeout_d;
      score_q   <= score_d;
      lives_q   <= lives_d;
      sw_s1_q   <= player_sw;
      sw_s2_q   <= sw_s1_q;
      sub_s1_q  <= submit_n;
      sub_s2_q  <= sub_s1_q;
      sub_s3_q  <= sub_s2_q;
    end
  end

  assign press      = !sub_s2_q && sub_s3_q;
  assign sw_one_hot = (sw_s2_q != 4'd0) && ((sw_s2_q & (sw_s2_q - 4'd1)) == 4'd0);
  assign answer_ok  = sw_one_hot && ((sw_s2_q & exp_q) != 4'd0);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    correct_d = correct_q;
    timeout_d = timeout_q;
    score_d   = score_q;
    lives_d   = lives_q;
    case (state_q)
      S_IDLE: begin
        if (round_start) begin
          exp_d     = expected;
          cnt_d     = CNT_LOAD;
          correct_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
        // a press on the final count still wins over the timeout
        if (press) begin
          correct_d = answer_ok;
          timeout_d = 1'b0;
          state_d   = S_RESULT;
        end else if (cnt_q == '0) begin
          correct_d = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_RESULT;
        end
      end
      S_RESULT: begin
        if (correct_q) begin
          if (score_q < SCORE_MAX) begin
            score_d = score_q + 8'd1;
          end
          state_d = S_IDLE;
        end else begin
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? S_OVER : S_IDLE;
        end
      end
      S_OVER: begin
        state_d = S_OVER;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    armed      = (state_q == S_ARMED);
    round_done = (state_q == S_RESULT);
    game_over  = (state_q == S_OVER);
    correct    = correct_q;
    timeout    = timeout_q;
    score      = score_q;
    lives      = lives_q;
  end

endmodule

// File: tb/tb_not_not_judge.sv
// Scoreboard bench for not_not_judge: stimulus pushes hand-computed round
// results, a monitor pops and checks them whenever round_done is seen.
`timescale 1ns/1ps
module tb_not_not_judge;

  localparam int CPR  = 16;
  localparam int MAXS = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       round_start = 1'b0;
  logic [3:0] expected = 4'd0;
  logic [3:0] player_sw = 4'd0;
  logic       submit_n = 1'b1;
  logic       armed, round_done, correct, timeout, game_over;
  logic [7:0] score;
  logic [1:0] lives;

  not_not_judge #(
    .CYCLES_PER_ROUND(CPR),
    .START_LIVES(3),
    .MAX_SCORE(MAXS)
  ) dut (
    .CLOCK_50(clk),
    .reset(reset),
    .round_start(round_start),
    .expected(expected),
    .player_sw(player_sw),
    .submit_n(submit_n),
    .armed(armed),
    .round_done(round_done),
    .correct(correct),
    .timeout(timeout),
    .score(score),
    .lives(lives),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic c;
    logic t;
    int   s;
    int   l;
    logic go;
    int   start;
    int   lat;
  } exp_t;

  exp_t q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int graded = 0;
  int m_score = 0;
  int m_lives = 3;
  logic m_c = 1'b0;
  logic m_t = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (round_done === 1'b1) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_round_done: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          chk("correct", correct, e.c);
          chk("timeout", timeout, e.t);
          chk("armed_at_done", armed, 0);
          chk("done_latency", cyc - e.start, e.lat);
          @(negedge clk);
          chk("round_done_width", round_done, 0);
          chk("score", score, e.s);
          chk("lives", lives, e.l);
          chk("game_over", game_over, e.go);
          graded++;
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    submit_n = 1'b1;
    round_start = 1'b0;
    player_sw = 4'd0;
    expected = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_score = 0;
    m_lives = 3;
    m_c = 1'b0;
    m_t = 1'b0;
    @(negedge clk);
    chk("rst_armed", armed, 0);
    chk("rst_round_done", round_done, 0);
    chk("rst_correct", correct, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 3);
    chk("rst_game_over", game_over, 0);
  endtask

  // d < 0: no press; otherwise submit_n falls d cycles after the start edge.
  // early >= 0 re-pulses round_start (with a different mask) during ARMED.
  task automatic do_round(input logic [3:0] e, input logic [3:0] sw, input int d,
                          input int hold, input int early, input logic exp_c);
    exp_t x;
    int last;
    int target;
    player_sw = sw;
    repeat (3) @(negedge clk);
    chk("correct_held", correct, m_c);
    chk("timeout_held", timeout, m_t);
    expected = e;
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
    chk("armed_after_start", armed, 1);
    chk("correct_cleared", correct, 0);
    chk("timeout_cleared", timeout, 0);
    if (exp_c) begin
      if (m_score < MAXS) m_score++;
    end else begin
      m_lives--;
    end
    m_c = exp_c;
    m_t = (d < 0);
    x.c = exp_c;
    x.t = (d < 0);
    x.s = m_score;
    x.l = m_lives;
    x.go = (m_lives == 0);
    x.start = cyc;
    x.lat = (d < 0) ? CPR : d + 3;
    target = graded + 1;
    q.push_back(x);
    last = early + 1;
    if (d >= 0 && d + hold > last) last = d + hold;
    for (int i = 0; i <= last; i++) begin
      round_start = (i == early);
      if (i == early) expected = ~e;
      if (i == d) submit_n = 1'b0;
      if (d >= 0 && i == d + hold) submit_n = 1'b1;
      @(negedge clk);
    end
    round_start = 1'b0;
    for (int k = 0; k < 60 && graded < target; k++) @(negedge clk);
    chk("round_graded", graded, target);
    if (graded < target) q.delete();
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #200_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    do_reset();
    // correct answer, key held 10 cycles -> graded once
    do_round(4'b1110, 4'b0100, 1, 10, -1, 1'b1);
    // multi-hot and zero patterns are wrong
    do_round(4'b0001, 4'b0011, 1, 2, -1, 1'b0);
    do_round(4'b0001, 4'b0000, 1, 2, -1, 1'b0);

    do_reset();
    do_round(4'b0001, 4'b0001, -1, 0, -1, 1'b0);   // timeout
    do_round(4'b1000, 4'b1000, 13, 3, -1, 1'b1);   // press lands on count 0
    do_round(4'b0010, 4'b0010, 6, 2, 2, 1'b1);     // early round_start ignored
    do_round(4'b0100, 4'b0100, 1, 2, -1, 1'b1);    // score saturates at 2
    do_round(4'b0001, 4'b0001, -1, 0, 5, 1'b0);    // countdown not reloaded

    // asynchronous reset in the middle of ARMED
    player_sw = 4'b0001;
    repeat (3) @(negedge clk);
    expected = 4'b0001;
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_armed", armed, 0);
    chk("midrst_score", score, 0);
    chk("midrst_lives", lives, 3);
    chk("midrst_round_done", round_done, 0);
    @(negedge clk);
    reset = 1'b0;
    m_score = 0;
    m_lives = 3;
    m_c = 1'b0;
    m_t = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_idle_armed", armed, 0);

    // three wrong rounds -> game over
    do_round(4'b0000, 4'b0001, 1, 2, -1, 1'b0);    // empty mask
    do_round(4'b0101, 4'b0101, 1, 2, -1, 1'b0);    // multi-hot overlap
    do_round(4'b0100, 4'b0010, 1, 2, -1, 1'b0);    // no overlap
    player_sw = 4'b0100;
    repeat (3) @(negedge clk);
    expected = 4'b0100;
    round_start = 1'b1;
    @(negedge clk);
    round_start = 1'b0;
    submit_n = 1'b0;
    repeat (3) @(negedge clk);
    submit_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("over_armed", armed, 0);
    chk("over_round_done", round_done, 0);
    chk("over_lives", lives, 0);
    chk("over_game_over", game_over, 1);
    chk("over_score", score, 0);
    chk("over_correct", correct, 0);
    chk("over_timeout", timeout, 0);

    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
